// File: rtl/cga_dbl_pkg.sv
// Shared constants, pixel type and sync-window helper for the CGA scan doubler.
package cga_dbl_pkg;

    localparam int DBL_ADDR_W   = 10;
    localparam int DBL_LINE_MAX = 1024;

    typedef logic [3:0] irgb_t;

    // Evaluated in 32-bit arithmetic so start+width can never wrap the address space.
    function automatic logic in_sync_window(input int unsigned idx,
                                            input int unsigned start,
                                            input int unsigned width);
        return (idx >= start) && (idx < start + width);
    endfunction

endpackage

// File: rtl/cga_line_doubler_if.sv
// Pixel-in / doubled-video-out bundle; slave is the doubler, master is the upstream/sink side.
interface cga_line_doubler_if;

    logic                 pix_strobe;
    cga_dbl_pkg::irgb_t   video;
    logic                 line_reset;
    cga_dbl_pkg::irgb_t   dbl_video;
    logic                 dbl_hsync;
    logic                 dbl_pass;
    logic                 overflow;

    modport master (
        output pix_strobe, video, line_reset,
        input  dbl_video, dbl_hsync, dbl_pass, overflow
    );

    modport slave (
        input  pix_strobe, video, line_reset,
        output dbl_video, dbl_hsync, dbl_pass, overflow
    );

endinterface

// File: rtl/cga_line_ram.sv
// Two-bank line store: one bank written while the other is read, registered read, no reset.
module cga_line_ram
    import cga_dbl_pkg::*;
#(
    parameter int LINE_MAX = DBL_LINE_MAX,
    parameter int ADDR_W   = DBL_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  irgb_t             wr_data,
    input  logic              rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output irgb_t             rd_data
);

    localparam int              DEPTH = 2 * LINE_MAX;
    localparam logic [ADDR_W:0] BANK  = (ADDR_W+1)'(LINE_MAX);

    irgb_t           mem [DEPTH];
    logic [ADDR_W:0] wr_idx;
    logic [ADDR_W:0] rd_idx;

    assign wr_idx = {1'b0, wr_addr} + (wr_sel ? BANK : '0);
    assign rd_idx = {1'b0, rd_addr} + (rd_sel ? BANK : '0);

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_idx] <= wr_data;
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/cga_line_doubler.sv
// Ping-pong line buffer scan doubler: captures one CGA line at pixel-strobe rate and
// replays it twice at clk rate with a regenerated hsync aligned to the replayed pixels.
module cga_line_doubler
    import cga_dbl_pkg::*;
#(
    parameter int          LINE_MAX = DBL_LINE_MAX,
    parameter int          ADDR_W   = DBL_ADDR_W,
    parameter int unsigned HS_START = 0,
    parameter int unsigned HS_WIDTH = 64
) (
    input logic               clk,
    input logic               rst_n,
    cga_line_doubler_if.slave bus
);

    localparam logic [ADDR_W-1:0] WR_LAST = (ADDR_W)'(LINE_MAX - 1);
    localparam logic [ADDR_W-1:0] A_ONE   = (ADDR_W)'(1);
    localparam logic [ADDR_W:0]   L_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   L_MAX   = (ADDR_W+1)'(LINE_MAX);

    // write side
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_full;
    logic              overflow_q;
    logic              we;
    logic [ADDR_W:0]   len_next;

    // read side
    logic [ADDR_W:0]   line_len;
    logic [ADDR_W-1:0] rd_addr;
    logic              pass_q;
    logic              rd_idle;
    logic              rd_active;
    logic              rd_last;
    logic              rd_vld;
    logic              rd_hs;
    irgb_t             ram_q;
    irgb_t             video_q;
    logic              hsync_q;

    // Once the last slot is written the address parks there; wr_full drops the rest.
    assign we = bus.pix_strobe && !wr_full;

    always_comb begin
        len_next = {1'b0, wr_addr} + {{ADDR_W{1'b0}}, we};
        if (wr_full)
            len_next = L_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel     <= 1'b0;
            wr_addr    <= '0;
            wr_full    <= 1'b0;
            overflow_q <= 1'b0;
            line_len   <= '0;
        end else begin
            if (bus.pix_strobe && wr_full)
                overflow_q <= 1'b1;
            if (bus.line_reset) begin
                wr_sel   <= ~wr_sel;
                wr_addr  <= '0;
                wr_full  <= 1'b0;
                line_len <= len_next;
            end else if (we) begin
                if (wr_addr == WR_LAST)
                    wr_full <= 1'b1;
                else
                    wr_addr <= wr_addr + A_ONE;
            end
        end
    end

    cga_line_ram #(
        .LINE_MAX (LINE_MAX),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we       (we),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (bus.video),
        .rd_sel   (~wr_sel),
        .rd_addr  (rd_addr),
        .rd_data  (ram_q)
    );

    assign rd_active = (line_len != '0) && !rd_idle;
    assign rd_last   = ({1'b0, rd_addr} == (line_len - L_ONE));

    // Replay counter: two passes over line_len pixels, then park blanked until the next line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            pass_q  <= 1'b0;
            rd_idle <= 1'b0;
        end else if (bus.line_reset) begin
            rd_addr <= '0;
            pass_q  <= 1'b0;
            rd_idle <= 1'b0;
        end else if (rd_active) begin
            if (rd_last) begin
                if (!pass_q) begin
                    rd_addr <= '0;
                    pass_q  <= 1'b1;
                end else begin
                    rd_idle <= 1'b1;
                end
            end else begin
                rd_addr <= rd_addr + A_ONE;
            end
        end
    end

    // Valid/hsync ride alongside the RAM read; a line_reset kills the in-flight read so the
    // aborted replay never reaches the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_hs   <= 1'b0;
            video_q <= '0;
            hsync_q <= 1'b0;
        end else begin
            rd_vld  <= rd_active && !bus.line_reset;
            rd_hs   <= rd_active && !bus.line_reset &&
                       in_sync_window(32'(rd_addr), HS_START, HS_WIDTH);
            video_q <= rd_vld ? ram_q : '0;
            hsync_q <= rd_hs;
        end
    end

    assign bus.dbl_video = video_q;
    assign bus.dbl_hsync = hsync_q;
    assign bus.dbl_pass  = pass_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cga_line_doubler.sv
// Bench for cga_line_doubler: line-level reference model checked every cycle, plus a
// table of line shapes, hand-written corner sequences and randomized lines.
module tb_cga_line_doubler;
    import cga_dbl_pkg::*;

    localparam int LMAX = 1024;
    localparam int HSS  = 0;
    localparam int HSW  = 64;

    typedef struct {
        int npix;
        int cad;
        bit ramp;
        int exp_len;
        bit exp_ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cga_line_doubler_if bus();

    cga_line_doubler #(
        .LINE_MAX (LMAX),
        .ADDR_W   (10),
        .HS_START (HSS),
        .HS_WIDTH (HSW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int cur[$];
    int done[$];
    int sent[$];
    int k      = -1;
    bit ovf_m  = 1'b0;
    int rise_k = -1;
    int since  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, $signed(act), $signed(exp));
        end
    endtask

    // Model: a line is the ordered list of strobed pixels (capped at LMAX); line_reset hands it
    // to replay and the output timeline is indexed by k = clocks since that line_reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            cur.delete();
            done.delete();
            k      = -1;
            ovf_m  = 1'b0;
            rise_k = -1;
        end else begin
            if (bus.pix_strobe === 1'b1) begin
                if (cur.size() < LMAX) cur.push_back(int'(bus.video));
                else                   ovf_m = 1'b1;
            end
            if (bus.line_reset === 1'b1) begin
                done   = cur;
                cur.delete();
                k      = 0;
                rise_k = -1;
            end else if (k >= 0) begin
                k++;
            end
        end
    end

    always @(negedge clk) begin : mon
        int n, idx, p;
        logic [3:0] ev;
        logic eh, ep;
        if (rst_n) begin
            n  = done.size();
            ev = '0;
            eh = 1'b0;
            ep = (k >= 0) && (n > 0) && (k >= n);
            if (k >= 2 && n > 0) begin
                idx = k - 2;
                p   = -1;
                if (idx < n)          p = idx;
                else if (idx < 2 * n) p = idx - n;
                if (p >= 0) begin
                    ev = 4'(done[p]);
                    eh = (p >= HSS) && (p < HSS + HSW);
                end
            end
            if (k != 0) begin
                chk("video", 32'(bus.dbl_video), 32'(ev));
                chk("hsync", 32'(bus.dbl_hsync), 32'(eh));
            end
            chk("pass", 32'(bus.dbl_pass), 32'(ep));
            chk("overflow", 32'(bus.overflow), 32'(ovf_m));
            if (k >= 0 && rise_k < 0 && bus.dbl_pass === 1'b1)
                rise_k = k;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        since++;
    endtask

    task automatic send_line(input int n, input int cad, input bit ramp);
        sent.delete();
        for (int i = 0; i < n; i++) begin
            bus.pix_strobe = 1'b1;
            bus.video      = ramp ? 4'(i % 16) : 4'($urandom);
            sent.push_back(int'(bus.video));
            tick();
            bus.pix_strobe = 1'b0;
            for (int c = 1; c < cad; c++) tick();
        end
    endtask

    task automatic pulse_lr(input bit with_pix);
        bus.line_reset = 1'b1;
        if (with_pix) begin
            bus.pix_strobe = 1'b1;
            bus.video      = 4'($urandom);
        end
        tick();
        bus.line_reset = 1'b0;
        bus.pix_strobe = 1'b0;
        since = 0;
    endtask

    task automatic pad_to(input int len);
        while (since < 2 * len + 4) tick();
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{912,  2, 1'b1, 912,  1'b0};
        tbl[1] = '{3,    2, 1'b0, 3,    1'b0};
        tbl[2] = '{0,    1, 1'b0, 0,    1'b0};
        tbl[3] = '{1,    1, 1'b0, 1,    1'b0};
        tbl[4] = '{1100, 1, 1'b0, 1024, 1'b1};
        tbl[5] = '{1024, 1, 1'b0, 1024, 1'b1};
        tbl[6] = '{700,  1, 1'b0, 700,  1'b1};

        bus.pix_strobe = 1'b0;
        bus.video      = '0;
        bus.line_reset = 1'b0;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_video", 32'(bus.dbl_video), 32'd0);
        chk("rst_hsync", 32'(bus.dbl_hsync), 32'd0);
        chk("rst_pass",  32'(bus.dbl_pass),  32'd0);
        chk("rst_ovf",   32'(bus.overflow),  32'd0);
        tick();

        // table: each line's replay length (pass rise time) and the sticky overflow flag
        for (int i = 0; i < 7; i++) begin
            send_line(tbl[i].npix, tbl[i].cad, tbl[i].ramp);
            if (i > 0) begin
                pad_to(tbl[i-1].exp_len);
                chk($sformatf("replay_len%0d", i-1), 32'(rise_k),
                    tbl[i-1].exp_len > 0 ? 32'(tbl[i-1].exp_len) : 32'hffff_ffff);
            end
            pulse_lr(1'b0);
            @(negedge clk);
            chk($sformatf("tbl_ovf%0d", i), 32'(bus.overflow), 32'(tbl[i].exp_ovf));
        end
        pad_to(tbl[6].exp_len);
        chk("replay_len6", 32'(rise_k), 32'(tbl[6].exp_len));

        // two line_resets three clocks apart: the following line must stay blank
        pulse_lr(1'b0);
        repeat (2) tick();
        pulse_lr(1'b0);
        repeat (20) tick();
        @(negedge clk);
        chk("blank_video", 32'(bus.dbl_video), 32'd0);
        chk("blank_hsync", 32'(bus.dbl_hsync), 32'd0);
        repeat (20) tick();

        // abort: new line_reset 300 clocks into the replay of a 912-pixel line
        send_line(912, 2, 1'b1);
        pulse_lr(1'b0);
        send_line(150, 2, 1'b0);
        pulse_lr(1'b0);
        repeat (2) tick();
        @(negedge clk);
        chk("abort_pix0", 32'(bus.dbl_video), 32'(sent[0]));
        chk("abort_pass", 32'(bus.dbl_pass), 32'd0);
        chk("abort_hs",   32'(bus.dbl_hsync), 32'd1);
        pad_to(150);

        // async reset mid-replay (second pass, inside hsync window), released off-edge
        send_line(100, 1, 1'b0);
        pulse_lr(1'b0);
        send_line(55, 2, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_video", 32'(bus.dbl_video), 32'd0);
        chk("arst_hsync", 32'(bus.dbl_hsync), 32'd0);
        chk("arst_pass",  32'(bus.dbl_pass),  32'd0);
        chk("arst_ovf",   32'(bus.overflow),  32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        send_line(20, 1, 1'b0);
        repeat (30) tick();
        @(negedge clk);
        chk("post_rst_blank", 32'(bus.dbl_video), 32'd0);
        pulse_lr(1'b0);
        pad_to(20);
        chk("post_rst_len", 32'(rise_k), 32'd20);

        // randomized lines, line_resets at arbitrary points (aborts, same-cycle strobes)
        for (int r = 0; r < 6; r++) begin
            int n, cad, gap;
            n   = $urandom_range(0, 1100);
            cad = $urandom_range(1, 3);
            gap = $urandom_range(0, 600);
            send_line(n, cad, 1'b0);
            repeat (gap) tick();
            pulse_lr(1'($urandom_range(0, 1)));
        end
        pad_to(LMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
